// File: rtl/backlight_ramp.sv
// Duty-cycle source for the backlight PWM: accepts a target over valid/ready and
// steps duty_out toward it by STEP, changing duty only at PWM period boundaries.
module backlight_ramp #(
  parameter int DUTY_W       = 8,
  parameter int PERIOD       = 256,
  parameter int STEP         = 1,
  parameter int DEFAULT_DUTY = 64
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              target_valid_in,
  input  logic [DUTY_W-1:0] target_in,
  output logic              target_ready_out,
  input  logic              hold_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic              period_start_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int                PRE_W    = $clog2(PERIOD);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PERIOD - 1);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DEFAULT_DUTY);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  // Handshake: a target transfers on a rising edge where target_valid_in and
  // target_ready_out are both high; ready is high exactly while no ramp is active.

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic [DUTY_W-1:0]  target_q, target_d;
  logic               done_q, done_d;

  logic               tick;
  logic [DUTY_W:0]    up_diff;
  logic [DUTY_W:0]    dn_diff;

  assign tick    = (pre_q == PRE_LAST);
  // One extra bit keeps the distance to target from wrapping near the range ends.
  assign up_diff = {1'b0, target_q} - {1'b0, duty_q};
  assign dn_diff = {1'b0, duty_q} - {1'b0, target_q};

  always_comb begin
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (target_valid_in) begin
          target_d = target_in;
          if (target_in > duty_q)      state_d = RAMP_UP;
          else if (target_in < duty_q) state_d = RAMP_DOWN;
          else                         done_d  = 1'b1;
        end
      end
      RAMP_UP: begin
        if (tick && !hold_in) begin
          if (up_diff <= STEP_X) begin
            duty_d  = target_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q + STEP_X[DUTY_W-1:0];
          end
        end
      end
      RAMP_DOWN: begin
        if (tick && !hold_in) begin
          if (dn_diff <= STEP_X) begin
            duty_d  = target_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q - STEP_X[DUTY_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      duty_q   <= DUTY_RST;
      target_q <= DUTY_RST;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign duty_out         = duty_q;
  assign period_start_out = (pre_q == '0);
  assign target_ready_out = (state_q == IDLE);
  assign busy_out         = (state_q != IDLE);
  assign done_out         = done_q;

endmodule

// File: tb/tb_backlight_ramp.sv
// Scoreboard bench for backlight_ramp: instance 0 uses PERIOD=256/STEP=1,
// instance 1 uses PERIOD=8/STEP=4 and takes randomized targets.
module tb_backlight_ramp;

  localparam int DEF = 64;

  typedef struct packed {
    int         cyc;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [2];
  logic [7:0] tgt   [2];
  logic       hold  [2];
  logic       ready [2];
  logic [7:0] duty  [2];
  logic       ps    [2];
  logic       busy  [2];
  logic       done  [2];

  int         ecnt;
  ev_t        exp_q  [2][$];
  ev_t        done_q [2][$];
  logic [7:0] mduty  [2];
  logic [7:0] last   [2];
  int         acc_c  [2];
  int         end_c  [2];
  int         n_cmp  = 0;
  int         n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Edges seen since reset release; prescaler before an edge equals ecnt mod PERIOD.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  backlight_ramp #(.DUTY_W(8), .PERIOD(256), .STEP(1), .DEFAULT_DUTY(DEF)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n),
    .target_valid_in(valid[0]), .target_in(tgt[0]), .target_ready_out(ready[0]),
    .hold_in(hold[0]), .duty_out(duty[0]), .period_start_out(ps[0]),
    .busy_out(busy[0]), .done_out(done[0])
  );

  backlight_ramp #(.DUTY_W(8), .PERIOD(8), .STEP(4), .DEFAULT_DUTY(DEF)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .target_valid_in(valid[1]), .target_in(tgt[1]), .target_ready_out(ready[1]),
    .hold_in(hold[1]), .duty_out(duty[1]), .period_start_out(ps[1]),
    .busy_out(busy[1]), .done_out(done[1])
  );

  function automatic int per_of(input int i);
    return (i == 0) ? 256 : 8;
  endfunction

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic model_busy(input int i, input int c);
    return (c >= acc_c[i]) && (c < end_c[i]);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle=%0d actual=%0d required=%0d", name, i, ecnt, act, exp);
    end
  endtask

  task automatic fail_line(input string name, input int i, input int act, input int exp);
    n_cmp++;
    n_fail++;
    $display("FAIL %s inst%0d cycle=%0d actual=%0d required=%0d", name, i, ecnt, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Accepted at edge e: steps land on period boundaries strictly after e, each
  // moving STEP toward the target and clamping on the last one. h periods of
  // hold are inserted after the first step.
  task automatic schedule(input int i, input logic [7:0] t, input int e, input int h);
    int p, s, d, td, j, c, idx;
    p = per_of(i);
    s = step_of(i);
    d = int'(mduty[i]);
    td = int'(t);
    acc_c[i] = e;
    if (td == d) begin
      done_q[i].push_back('{cyc: e, val: t});
      end_c[i] = e;
    end else begin
      j = (e / p + 1) * p;
      c = e;
      idx = 0;
      while (d != td) begin
        if (td > d) d = (td - d <= s) ? td : d + s;
        else        d = (d - td <= s) ? td : d - s;
        c = j + idx * p + ((idx >= 1) ? h * p : 0);
        exp_q[i].push_back('{cyc: c, val: 8'(d)});
        idx++;
      end
      done_q[i].push_back('{cyc: c, val: t});
      end_c[i] = c;
    end
    mduty[i] = t;
  endtask

  // ---------------- driver tasks ----------------
  task automatic request(input int i, input logic [7:0] t, input int h);
    int  k, j1;
    logic acc;
    @(negedge clk);
    valid[i] = 1'b1;
    tgt[i]   = t;
    k   = ecnt;
    acc = !model_busy(i, k);
    @(posedge clk);
    #1;
    if (acc) schedule(i, t, k + 1, h);
    @(negedge clk);
    valid[i] = 1'b0;
    if (acc && h > 0) begin
      j1 = ((k + 1) / per_of(i) + 1) * per_of(i);
      while (ecnt != j1) @(negedge clk);
      hold[i] = 1'b1;
      while (ecnt != j1 + h * per_of(i)) @(negedge clk);
      hold[i] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int i);
    while (ecnt < end_c[i]) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // Called with rst_n already low: checks the asynchronous reset values, then releases.
  task automatic reset_body();
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_duty", i, int'(duty[i]), DEF);
      check("rst_ready", i, int'(ready[i]), 1);
      check("rst_busy", i, int'(busy[i]), 0);
      check("rst_done", i, int'(done[i]), 0);
      check("rst_period_start", i, int'(ps[i]), 1);
      exp_q[i].delete();
      done_q[i].delete();
      mduty[i] = 8'(DEF);
      last[i]  = 8'(DEF);
      acc_c[i] = 0;
      end_c[i] = 0;
      valid[i] = 1'b0;
      hold[i]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int i);
    ev_t e;
    check("period_start", i, int'(ps[i]), int'((ecnt % per_of(i)) == 0));
    check("busy", i, int'(busy[i]), int'(model_busy(i, ecnt)));
    check("ready", i, int'(ready[i]), int'(!model_busy(i, ecnt)));
    if (duty[i] !== last[i]) begin
      if (exp_q[i].size() == 0) begin
        fail_line("duty_unexpected", i, int'(duty[i]), int'(last[i]));
      end else begin
        e = exp_q[i].pop_front();
        check("duty_value", i, int'(duty[i]), int'(e.val));
        check("duty_cycle", i, ecnt, e.cyc);
      end
      last[i] = duty[i];
    end
    while (exp_q[i].size() > 0 && exp_q[i][0].cyc < ecnt) begin
      e = exp_q[i].pop_front();
      fail_line("duty_missing", i, int'(duty[i]), int'(e.val));
    end
    if (done[i]) begin
      if (done_q[i].size() == 0) begin
        fail_line("done_unexpected", i, 1, 0);
      end else begin
        e = done_q[i].pop_front();
        check("done_cycle", i, ecnt, e.cyc);
        check("done_duty", i, int'(duty[i]), int'(e.val));
      end
    end
    while (done_q[i].size() > 0 && done_q[i][0].cyc < ecnt) begin
      e = done_q[i].pop_front();
      fail_line("done_missing", i, 0, 1);
    end
  endtask

  always @(negedge clk) if (rst_n) mon(0);
  always @(negedge clk) if (rst_n) mon(1);

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      tgt[i]   = '0;
      hold[i]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2;
    reset_body();

    // Equal target while holding: done next cycle, no ramp.
    hold[0] = 1'b1;
    request(0, 8'd64, 0);
    hold[0] = 1'b0;
    wait_idle(0);

    // Ramp up by one per period, with a request arriving mid-ramp that must be dropped.
    request(0, 8'd68, 0);
    repeat (300) @(negedge clk);
    request(0, 8'd20, 0);
    wait_idle(0);

    request(0, 8'd64, 0);
    wait_idle(0);

    // Hold across three ticks after the first step.
    request(0, 8'd68, 3);
    wait_idle(0);

    // Coarse step with clamp at the end: 60,56,...,12,10.
    request(1, 8'd10, 0);
    wait_idle(1);

    for (int n = 0; n < 30; n++) begin
      request(1, 8'($urandom_range(0, 255)), 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
        request(1, 8'($urandom_range(0, 255)), 0);
      end
      wait_idle(1);
      repeat ($urandom_range(0, 9)) @(negedge clk);
    end

    // Boundary targets.
    request(1, 8'd255, 0);
    wait_idle(1);
    request(1, 8'd0, 0);
    wait_idle(1);

    // Reset in the middle of a ramp, then a short ramp afterwards.
    request(1, 8'd200, 0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    reset_body();
    request(1, 8'd66, 0);
    wait_idle(1);

    for (int i = 0; i < 2; i++) begin
      check("duty_queue_drained", i, exp_q[i].size(), 0);
      check("done_queue_drained", i, done_q[i].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
